scr1_axi_slv_mem: RTL and testbench

//  AXI4 slave-to-SCR1 memory-interface bridge: the responder end of the AXI links the core's bridges drive.

---
 rtl/scr1_axi_slv_mem_pkg.sv | 30 +++
 rtl/scr1_axi_slv_mem.sv | 254 +++++++++++++++++++++++++
 tb/tb_scr1_axi_slv_mem.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scr1_axi_slv_mem_pkg.sv
// Shared types for the AXI4 slave memory bridge: SCR1 memory-interface enums
// and AXI response/burst encodings.
package scr1_axi_slv_mem_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    localparam logic [1:0] SCR1_AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] SCR1_AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] SCR1_AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] SCR1_AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] SCR1_AXI_BURST_INCR  = 2'b01;

endpackage

// File: rtl/scr1_axi_slv_mem.sv
// AXI4 slave to SCR1 memory-interface bridge; one burst outstanding, split into single-beat requests.
// Optional address-window check: define SCR1_AXI_SLV_ADDR_CHK_EN.
module scr1_axi_slv_mem
    import scr1_axi_slv_mem_pkg::*;
#(
    parameter int                         SCR1_AXI_IDWIDTH = 4,
    parameter int                         SCR1_ADDR_WIDTH  = 32,
    parameter logic [SCR1_ADDR_WIDTH-1:0] SCR1_SLV_BASE    = 32'h0000_0000,
    parameter logic [SCR1_ADDR_WIDTH-1:0] SCR1_SLV_MASK    = 32'hFFFF_0000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SCR1_AXI_IDWIDTH-1:0] awid,
    input  logic [SCR1_ADDR_WIDTH-1:0]  awaddr,
    input  logic [7:0]                  awlen,
    input  logic [2:0]                  awsize,
    input  logic [1:0]                  awburst,
    input  logic                        awlock,
    input  logic [3:0]                  awcache,
    input  logic [2:0]                  awprot,
    input  logic [3:0]                  awregion,
    input  logic [3:0]                  awqos,
    input  logic                        awuser,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [31:0]                 wdata,
    input  logic [3:0]                  wstrb,
    input  logic                        wlast,
    input  logic                        wuser,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [SCR1_AXI_IDWIDTH-1:0] bid,
    output logic [1:0]                  bresp,
    output logic                        buser,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [SCR1_AXI_IDWIDTH-1:0] arid,
    input  logic [SCR1_ADDR_WIDTH-1:0]  araddr,
    input  logic [7:0]                  arlen,
    input  logic [2:0]                  arsize,
    input  logic [1:0]                  arburst,
    input  logic                        arlock,
    input  logic [3:0]                  arcache,
    input  logic [2:0]                  arprot,
    input  logic [3:0]                  arregion,
    input  logic [3:0]                  arqos,
    input  logic                        aruser,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [SCR1_AXI_IDWIDTH-1:0] rid,
    output logic [31:0]                 rdata,
    output logic [1:0]                  rresp,
    output logic                        rlast,
    output logic                        ruser,
    output logic                        rvalid,
    input  logic                        rready,
    output logic                        mem_req,
    input  logic                        mem_req_ack,
    output type_scr1_mem_cmd_e          mem_cmd,
    output type_scr1_mem_width_e        mem_width,
    output logic [SCR1_ADDR_WIDTH-1:0]  mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic [31:0]                 mem_rdata,
    input  type_scr1_mem_resp_e         mem_resp,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_MEM  = 3'd1,
        ST_RD_RSP  = 3'd2,
        ST_WR_DATA = 3'd3,
        ST_WR_MEM  = 3'd4,
        ST_WR_RSP  = 3'd5
    } state_e;

    function automatic type_scr1_mem_width_e size2width(input logic [2:0] size);
        case (size)
            3'd0:    size2width = SCR1_MEM_WIDTH_BYTE;
            3'd1:    size2width = SCR1_MEM_WIDTH_HWORD;
            default: size2width = SCR1_MEM_WIDTH_WORD;
        endcase
    endfunction

    state_e                      state, state_next;
    logic [SCR1_AXI_IDWIDTH-1:0] id_q;
    logic [SCR1_ADDR_WIDTH-1:0]  addr_q, addr_inc;
    logic [7:0]                  len_q, cnt_q;
    logic [2:0]                  size_q;
    logic                        err_q, err_acc_q, prio_q, acked_q;
    logic [1:0]                  err_resp_q, rresp_q;
    logic [31:0]                 wdata_q, rdata_q;
    logic                        gnt_rd, gnt_wr, contend, last_beat, mem_done, skip_w;
    logic                        ar_unsup, aw_unsup, ar_hit, aw_hit, ar_miss, aw_miss;
    logic                        ar_err, aw_err;
    logic [1:0]                  ar_err_resp, aw_err_resp;

    assign ar_unsup = (arsize > 3'd2) || (arburst != SCR1_AXI_BURST_INCR);
    assign aw_unsup = (awsize > 3'd2) || (awburst != SCR1_AXI_BURST_INCR);
    assign ar_hit   = (araddr & SCR1_SLV_MASK) == SCR1_SLV_BASE;
    assign aw_hit   = (awaddr & SCR1_SLV_MASK) == SCR1_SLV_BASE;

`ifdef SCR1_AXI_SLV_ADDR_CHK_EN
    assign ar_miss = ~ar_hit;
    assign aw_miss = ~aw_hit;
    logic unused_ok;
    assign unused_ok = ^{awlock, awcache, awprot, awregion, awqos, awuser, wuser,
                         arlock, arcache, arprot, arregion, arqos, aruser};
`else
    assign ar_miss = 1'b0;
    assign aw_miss = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{awlock, awcache, awprot, awregion, awqos, awuser, wuser,
                         arlock, arcache, arprot, arregion, arqos, aruser, ar_hit, aw_hit};
`endif

    // Unsupported size/burst wins over a window miss so the master sees SLVERR first.
    assign ar_err      = ar_unsup | ar_miss;
    assign aw_err      = aw_unsup | aw_miss;
    assign ar_err_resp = ar_unsup ? SCR1_AXI_RESP_SLVERR : SCR1_AXI_RESP_DECERR;
    assign aw_err_resp = aw_unsup ? SCR1_AXI_RESP_SLVERR : SCR1_AXI_RESP_DECERR;

    // prio_q=0 favours reads; it flips only when both channels contend so a
    // pending loser is served next without losing its turn.
    assign contend   = arvalid & awvalid;
    assign gnt_rd    = (state == ST_IDLE) & arvalid & (~awvalid | ~prio_q);
    assign gnt_wr    = (state == ST_IDLE) & awvalid & ~gnt_rd;
    assign last_beat = (cnt_q == len_q);
    assign skip_w    = err_q | (wstrb == 4'b0000);
    assign addr_inc  = addr_q + (SCR1_ADDR_WIDTH'(1) << size_q);
    // The response may arrive with the ack or any later cycle.
    assign mem_done  = (acked_q | (mem_req & mem_req_ack)) & (mem_resp != SCR1_MEM_RESP_NOTRDY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        arready    = 1'b0;
        awready    = 1'b0;
        wready     = 1'b0;
        rvalid     = 1'b0;
        bvalid     = 1'b0;
        mem_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                arready = gnt_rd;
                awready = gnt_wr;
                if (gnt_rd)      state_next = ar_err ? ST_RD_RSP : ST_RD_MEM;
                else if (gnt_wr) state_next = ST_WR_DATA;
            end
            ST_RD_MEM: begin
                mem_req = ~acked_q;
                if (mem_done) state_next = ST_RD_RSP;
            end
            ST_RD_RSP: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (last_beat) state_next = ST_IDLE;
                    else           state_next = err_q ? ST_RD_RSP : ST_RD_MEM;
                end
            end
            ST_WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    if (!skip_w)        state_next = ST_WR_MEM;
                    else if (last_beat) state_next = ST_WR_RSP;
                end
            end
            ST_WR_MEM: begin
                mem_req = ~acked_q;
                if (mem_done) state_next = last_beat ? ST_WR_RSP : ST_WR_DATA;
            end
            ST_WR_RSP: begin
                bvalid = 1'b1;
                if (bready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q <= '0; addr_q <= '0; len_q <= '0; cnt_q <= '0; size_q <= '0;
            err_q <= 1'b0; err_resp_q <= SCR1_AXI_RESP_OKAY; err_acc_q <= 1'b0;
            prio_q <= 1'b0; acked_q <= 1'b0; wdata_q <= '0; rdata_q <= '0;
            rresp_q <= SCR1_AXI_RESP_OKAY;
        end else begin
            if (mem_done)                  acked_q <= 1'b0;
            else if (mem_req & mem_req_ack) acked_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (contend & (gnt_rd | gnt_wr)) prio_q <= ~prio_q;
                    if (gnt_rd) begin
                        id_q <= arid; addr_q <= araddr; len_q <= arlen; size_q <= arsize;
                        err_q <= ar_err; err_resp_q <= ar_err_resp;
                        err_acc_q <= 1'b0; cnt_q <= '0;
                        if (ar_err) begin
                            rdata_q <= '0;
                            rresp_q <= ar_err_resp;
                        end
                    end else if (gnt_wr) begin
                        id_q <= awid; addr_q <= awaddr; len_q <= awlen; size_q <= awsize;
                        err_q <= aw_err; err_resp_q <= aw_err_resp;
                        err_acc_q <= 1'b0; cnt_q <= '0;
                    end
                end
                ST_RD_MEM: if (mem_done) begin
                    rdata_q <= mem_rdata << {addr_q[1:0], 3'b000};
                    rresp_q <= (mem_resp == SCR1_MEM_RESP_RDY_ER) ? SCR1_AXI_RESP_SLVERR
                                                                  : SCR1_AXI_RESP_OKAY;
                end
                ST_RD_RSP: if (rready & ~last_beat) begin
                    addr_q <= addr_inc;
                    cnt_q  <= cnt_q + 8'd1;
                end
                ST_WR_DATA: if (wvalid) begin
                    wdata_q <= wdata;
                    if (wlast != last_beat) err_acc_q <= 1'b1;
                    if (skip_w & ~last_beat) begin
                        addr_q <= addr_inc;
                        cnt_q  <= cnt_q + 8'd1;
                    end
                end
                ST_WR_MEM: if (mem_done) begin
                    if (mem_resp == SCR1_MEM_RESP_RDY_ER) err_acc_q <= 1'b1;
                    if (~last_beat) begin
                        addr_q <= addr_inc;
                        cnt_q  <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_cmd   = (state == ST_WR_MEM) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
    assign mem_width = size2width(size_q);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q >> {addr_q[1:0], 3'b000};

    assign rid       = id_q;
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign rlast     = (state == ST_RD_RSP) & last_beat;
    assign ruser     = 1'b0;
    assign bid       = id_q;
    assign bresp     = err_q ? err_resp_q : (err_acc_q ? SCR1_AXI_RESP_SLVERR : SCR1_AXI_RESP_OKAY);
    assign buser     = 1'b0;
    assign dbg_state = state;

endmodule

// File: tb/tb_scr1_axi_slv_mem.sv
// Bench for scr1_axi_slv_mem: table of bursts plus hand-written arbitration,
// backpressure and mid-burst reset sequences, checked through expectation queues.
module tb_scr1_axi_slv_mem;
  import scr1_axi_slv_mem_pkg::*;

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, dbg_state;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, buser;
  logic arvalid, arready, rlast, rvalid, rready, ruser, mem_req, mem_req_ack;
  type_scr1_mem_cmd_e mem_cmd;
  type_scr1_mem_width_e mem_width;
  type_scr1_mem_resp_e mem_resp;

  scr1_axi_slv_mem dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(1'b0), .awcache(4'h0), .awprot(3'h0), .awregion(4'h0), .awqos(4'h0), .awuser(1'b0),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(1'b0), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(1'b0), .arcache(4'h0), .arprot(3'h0), .arregion(4'h0), .arqos(4'h0), .aruser(1'b0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready),
    .mem_req(mem_req), .mem_req_ack(mem_req_ack), .mem_cmd(mem_cmd), .mem_width(mem_width),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .dbg_state(dbg_state)
  );

  typedef struct {
    bit         is_rd;
    logic [3:0] id;
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    bit         mem_err;
    bit         strb_zero;
    bit         wlast_bad;
    int         exp_nmem;
    logic [1:0] exp_resp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  // {cmd, width, addr, wdata}, {rid, rdata, rresp, rlast}, {bid, bresp}, {err, rdata}, {wdata, wstrb, wlast}
  logic [66:0] exp_mem_q[$];
  logic [38:0] exp_r_q[$];
  logic [5:0]  exp_b_q[$];
  logic [32:0] plan_q[$];
  logic [36:0] w_q[$];
  int mem_cnt = 0;
  int stall_at = -1;
  logic [1:0] first_resp;
  bit got_first;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Memory target: random ack delay, response with the ack or one cycle later.
  initial begin
    logic [32:0] p;
    logic [66:0] e;
    logic [31:0] wd_act;
    bit pend;
    logic [32:0] pend_p;
    pend = 0;
    mem_req_ack = 1'b0;
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_req_ack = 1'b0;
      mem_resp = SCR1_MEM_RESP_NOTRDY;
      if (!rst_n) pend = 0;
      else if (pend) begin
        mem_resp = pend_p[32] ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        mem_rdata = pend_p[31:0];
        pend = 0;
      end else if (mem_req && mem_cnt != stall_at && $urandom_range(0, 3) != 0) begin
        mem_req_ack = 1'b1;
        mem_cnt++;
        if (exp_mem_q.size() == 0 || plan_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_req: unexpected request at addr %0h", mem_addr);
        end else begin
          e = exp_mem_q.pop_front();
          p = plan_q.pop_front();
          wd_act = (mem_cmd == SCR1_MEM_CMD_WR) ? mem_wdata : 32'h0;
          check("mem_req", {mem_cmd, mem_width, mem_addr, wd_act}, e);
          if ($urandom_range(0, 1) == 1) begin
            mem_resp = p[32] ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            mem_rdata = p[31:0];
          end else begin
            pend = 1;
            pend_p = p;
          end
        end
      end
    end
  end

  // R/B monitor: handshakes seen at the falling edge complete on the next rising edge.
  initial begin
    logic [38:0] er;
    logic [5:0] eb;
    forever begin
      @(negedge clk);
      if (rst_n && rvalid && rready) begin
        if (exp_r_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_beat: unexpected beat rid %0h", rid);
        end else begin
          er = exp_r_q.pop_front();
          check("r_beat", {rid, rdata, rresp, rlast}, er);
        end
        if (!got_first) begin first_resp = rresp; got_first = 1; end
      end
      if (rst_n && bvalid && bready) begin
        if (exp_b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_resp: unexpected response bid %0h", bid);
        end else begin
          eb = exp_b_q.pop_front();
          check("b_resp", {bid, bresp}, eb);
        end
        if (!got_first) begin first_resp = bresp; got_first = 1; end
      end
    end
  end

  // Reference model of one burst: pushes W beats, memory plan and all expectations.
  task automatic push_burst(input vec_t v, input int row);
    logic [31:0] a, rd, wd;
    logic [3:0] strb;
    logic unsup, err_any, last, wl, beat_err;
    unsup = (v.size > 3'd2) || (v.burst != 2'b01);
    err_any = unsup;
    a = v.addr;
    for (int b = 0; b <= int'(v.len); b++) begin
      beat_err = v.mem_err && (b == 0);
      last = (b == int'(v.len));
      if (v.is_rd) begin
        rd = 32'hA5A5_1234 ^ (row << 16) ^ b;
        if (unsup) exp_r_q.push_back({v.id, 32'h0, SE, last});
        else begin
          plan_q.push_back({beat_err, rd});
          exp_mem_q.push_back({1'b0, v.size[1:0], a, 32'h0});
          exp_r_q.push_back({v.id, rd << {a[1:0], 3'b000}, beat_err ? SE : OK, last});
        end
      end else begin
        wd = $urandom;
        strb = v.strb_zero ? 4'h0 : 4'($urandom_range(1, 15));
        wl = v.wlast_bad ? (b == 0) : last;
        if (wl != last) err_any = 1;
        w_q.push_back({wd, strb, wl});
        if (!unsup && strb != 4'h0) begin
          plan_q.push_back({beat_err, 32'h0});
          exp_mem_q.push_back({1'b1, v.size[1:0], a, wd >> {a[1:0], 3'b000}});
          if (beat_err) err_any = 1;
        end
      end
      a = a + (32'd1 << v.size);
    end
    if (!v.is_rd) exp_b_q.push_back({v.id, err_any ? SE : OK});
  endtask

  task automatic set_ar(input vec_t v);
    arid = v.id; araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst;
    arvalid = 1'b1;
  endtask

  task automatic set_aw(input vec_t v);
    awid = v.id; awaddr = v.addr; awlen = v.len; awsize = v.size; awburst = v.burst;
    awvalid = 1'b1;
  endtask

  task automatic hs_ar();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) timeout("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic hs_aw();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) timeout("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w();
    logic [36:0] w;
    bit ok = 0;
    w = w_q.pop_front();
    wdata = w[36:5]; wstrb = w[4:1]; wlast = w[0]; wvalid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    if (!ok) timeout("w_handshake");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_mem_q.size() == 0 && exp_r_q.size() == 0 && exp_b_q.size() == 0 &&
          plan_q.size() == 0 && dbg_state == 3'd0 && !rvalid && !bvalid) begin
        ok = 1; break;
      end
    end
    if (!ok) timeout("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int row);
    int base;
    base = mem_cnt;
    got_first = 0;
    push_burst(v, row);
    if (v.is_rd) begin
      set_ar(v); hs_ar();
    end else begin
      set_aw(v); hs_aw();
      for (int b = 0; b <= int'(v.len); b++) send_w();
    end
    wait_idle();
    check($sformatf("nmem_row%0d", row), mem_cnt - base, v.exp_nmem);
    check($sformatf("resp_row%0d", row), first_resp, v.exp_resp);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t vr, vw;
    logic [38:0] eh;
    bit ok;

    tbl[0] = '{1, 4'd1,  32'h0000_0100, 8'd0, 3'd2, 2'd1, 0, 0, 0, 1, OK};
    tbl[1] = '{0, 4'd2,  32'h0000_0203, 8'd3, 3'd0, 2'd1, 0, 0, 0, 4, OK};
    tbl[2] = '{1, 4'd3,  32'h0000_0010, 8'd1, 3'd1, 2'd2, 0, 0, 0, 0, SE};
    tbl[3] = '{1, 4'd4,  32'h0000_0402, 8'd2, 3'd1, 2'd1, 1, 0, 0, 3, SE};
    tbl[4] = '{0, 4'd5,  32'h0000_0300, 8'd1, 3'd2, 2'd1, 1, 0, 0, 2, SE};
    tbl[5] = '{0, 4'd6,  32'h0000_0500, 8'd0, 3'd3, 2'd1, 0, 0, 0, 0, SE};
    tbl[6] = '{1, 4'd7,  32'hFFFF_FFFC, 8'd1, 3'd2, 2'd1, 0, 0, 0, 2, OK};
    tbl[7] = '{0, 4'd8,  32'h0000_0601, 8'd1, 3'd1, 2'd1, 0, 0, 0, 2, OK};
    tbl[8] = '{0, 4'd9,  32'h0000_0700, 8'd1, 3'd2, 2'd1, 0, 1, 0, 0, OK};
    tbl[9] = '{0, 4'd10, 32'h0000_0740, 8'd1, 3'd2, 2'd1, 0, 0, 1, 2, SE};

    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_arready", arready, 0);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_bresp", bresp, OK);
    check("rst_rresp", rresp, OK);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention from reset: read first, then the pending write.
    vr = '{1, 4'hA, 32'h0000_0800, 8'd0, 3'd2, 2'd1, 0, 0, 0, 1, OK};
    vw = '{0, 4'hB, 32'h0000_0900, 8'd0, 3'd2, 2'd1, 0, 0, 0, 1, OK};
    push_burst(vr, 100);
    push_burst(vw, 101);
    set_ar(vr); set_aw(vw);
    @(negedge clk);
    check("arb1_arready", arready, 1);
    check("arb1_awready", awready, 0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    hs_aw();
    send_w();
    wait_idle();

    // Second contention: write wins this time.
    vr.id = 4'hC; vr.addr = 32'h0000_0804;
    vw.id = 4'hD; vw.addr = 32'h0000_0904;
    push_burst(vw, 103);
    push_burst(vr, 102);
    set_ar(vr); set_aw(vw);
    @(negedge clk);
    check("arb2_awready", awready, 1);
    check("arb2_arready", arready, 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    send_w();
    hs_ar();
    wait_idle();

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Error beat held under rready=0: R outputs must stay put.
    vr = '{1, 4'h5, 32'h0000_0A00, 8'd1, 3'd2, 2'd1, 1, 0, 0, 2, SE};
    push_burst(vr, 104);
    rready = 1'b0;
    set_ar(vr); hs_ar();
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; break; end
    end
    if (!ok) timeout("bp_rvalid");
    eh = exp_r_q[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rvalid", rvalid, 1);
      check("bp_rresp", rresp, eh[2:1]);
      check("bp_rdata", rdata, eh[34:3]);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_idle();

    // Asynchronous reset while beat 2 of a write waits for its ack.
    vw = '{0, 4'h6, 32'h0000_0B00, 8'd3, 3'd2, 2'd1, 0, 0, 0, 0, OK};
    push_burst(vw, 105);
    stall_at = mem_cnt + 2;
    set_aw(vw); hs_aw();
    for (int b = 0; b < 3; b++) send_w();
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_req && mem_cnt == stall_at) begin ok = 1; break; end
    end
    if (!ok) timeout("rst_wr_mem");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_bvalid", bvalid, 0);
    exp_mem_q.delete(); plan_q.delete(); w_q.delete(); exp_b_q.delete(); exp_r_q.delete();
    stall_at = -1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vw = '{0, 4'h7, 32'h0000_0C00, 8'd0, 3'd2, 2'd1, 0, 0, 0, 1, OK};
    run_vec(vw, 106);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
